// File: rtl/fpgart_pkg.sv
// Shared canvas definitions for the fpgart pixel pipeline: canvas geometry,
// bank select encodings and the rectangle fill state machine encoding.
package fpgart_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  // Canvas and bank constants shared with memory_controller
  localparam int   CANVAS_PIXELS = SCREEN_W * SCREEN_H;
  localparam logic BANK_A        = 1'b0;
  localparam logic BANK_B        = 1'b1;

  localparam logic [X_W-1:0]    X_LAST     = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(SCREEN_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } fill_state_t;

  // Address of pixel (0, y); only evaluated once per command in SETUP
  function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ROW_STRIDE;
  endfunction

endpackage

// File: rtl/rect_clip.sv
// Combinational corner ordering and canvas clipping for rect_fill_engine.
// Produces the inclusive bounding box limited to the visible canvas, and
// flags rectangles that lie entirely off-canvas.
module rect_clip
  import fpgart_pkg::*;
(
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] xmin,
  output logic [X_W-1:0] xmax,
  output logic [Y_W-1:0] ymin,
  output logic [Y_W-1:0] ymax,
  output logic           empty
);

  function automatic logic [X_W-1:0] sat_x(input logic [X_W-1:0] v);
    return (v > X_LAST) ? X_LAST : v;
  endfunction

  function automatic logic [Y_W-1:0] sat_y(input logic [Y_W-1:0] v);
    return (v > Y_LAST) ? Y_LAST : v;
  endfunction

  logic [X_W-1:0] xhi;
  logic [Y_W-1:0] yhi;

  // Order the corners, then saturate the far edges to the canvas
  always_comb begin
    xmin  = (x0 < x1) ? x0 : x1;
    xhi   = (x0 < x1) ? x1 : x0;
    ymin  = (y0 < y1) ? y0 : y1;
    yhi   = (y0 < y1) ? y1 : y0;
    xmax  = sat_x(xhi);
    ymax  = sat_y(yhi);
    empty = (xmin > X_LAST) || (ymin > Y_LAST);
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: latches one rectangle command, orders and clips it
// to the canvas, then streams one pixel write per clock in raster order to
// the dual-bank canvas memory controller.
// Optional build macro RECT_OUTLINE_EN adds iOutline, which restricts writes
// to the rectangle border while keeping the same walk length.
module rect_fill_engine
  import fpgart_pkg::*;
(
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iStart,
  input  logic [X_W-1:0]      iX0,
  input  logic [Y_W-1:0]      iY0,
  input  logic [X_W-1:0]      iX1,
  input  logic [Y_W-1:0]      iY1,
  input  logic [COLOUR_W-1:0] iColour,
  input  logic                iBank,
`ifdef RECT_OUTLINE_EN
  input  logic                iOutline,
`endif
  output logic                oBusy,
  output logic                oDone,
  output logic [ADDR_W-1:0]   oAddress,
  output logic [COLOUR_W-1:0] oData,
  output logic                oWren,
  output logic                oChipSelect
);

  fill_state_t state, state_nxt;

  logic [X_W-1:0]      x0_p0, x1_p0;
  logic [Y_W-1:0]      y0_p0, y1_p0;
  logic [COLOUR_W-1:0] colour_p0;
  logic                bank_p0;
  logic                outline_p0;

  logic [X_W-1:0]      c_xmin, c_xmax;
  logic [Y_W-1:0]      c_ymin, c_ymax;
  logic                c_empty;

  logic [X_W-1:0]      xmin_p1, xmax_p1, x_p1;
  logic [Y_W-1:0]      ymin_p1, ymax_p1, y_p1;
  logic [ADDR_W-1:0]   rowbase_p1;

  logic                row_end;
  logic                last_px;
  logic                pix_wr;

  rect_clip u_clip (
    .x0    (x0_p0),
    .y0    (y0_p0),
    .x1    (x1_p0),
    .y1    (y1_p0),
    .xmin  (c_xmin),
    .xmax  (c_xmax),
    .ymin  (c_ymin),
    .ymax  (c_ymax),
    .empty (c_empty)
  );

  assign row_end = (x_p1 == xmax_p1);
  assign last_px = row_end && (y_p1 == ymax_p1);

  // Border test for outline mode; solid fills write every walked pixel
  always_comb begin
    pix_wr = 1'b1;
`ifdef RECT_OUTLINE_EN
    if (outline_p0) begin
      pix_wr = (x_p1 == xmin_p1) || (x_p1 == xmax_p1) ||
               (y_p1 == ymin_p1) || (y_p1 == ymax_p1);
    end
`endif
  end

  // Command register stage: capture the command on the accepting edge only
  always_ff @(posedge iClk) begin
    if (state == ST_IDLE && iStart) begin
      x0_p0     <= iX0;
      y0_p0     <= iY0;
      x1_p0     <= iX1;
      y1_p0     <= iY1;
      colour_p0 <= iColour;
      bank_p0   <= iBank;
`ifdef RECT_OUTLINE_EN
      outline_p0 <= iOutline;
`else
      outline_p0 <= 1'b0;
`endif
    end
  end

  // Walk stage: bounds registered in SETUP, raster position advanced in FILL
  always_ff @(posedge iClk) begin
    if (state == ST_SETUP) begin
      xmin_p1    <= c_xmin;
      xmax_p1    <= c_xmax;
      ymin_p1    <= c_ymin;
      ymax_p1    <= c_ymax;
      x_p1       <= c_xmin;
      y_p1       <= c_ymin;
      rowbase_p1 <= row_base(c_ymin);
    end else if (state == ST_FILL) begin
      if (row_end) begin
        x_p1       <= xmin_p1;
        y_p1       <= y_p1 + Y_W'(1);
        rowbase_p1 <= rowbase_p1 + ROW_STRIDE;
      end else begin
        x_p1 <= x_p1 + X_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge iClk) begin
    if (iReset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iStart) state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = c_empty ? ST_DONE : ST_FILL;
      ST_FILL:  if (last_px) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output register stage: memory-side signals follow the state by one edge
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oWren       <= 1'b0;
      oAddress    <= '0;
      oData       <= '0;
      oChipSelect <= 1'b0;
    end else begin
      oWren <= 1'b0;
      oDone <= 1'b0;
      case (state)
        ST_IDLE:  if (iStart) oBusy <= 1'b1;
        ST_SETUP: oChipSelect <= bank_p0;
        ST_FILL: begin
          oWren    <= pix_wr;
          oAddress <= rowbase_p1 + ADDR_W'(x_p1);
          oData    <= colour_p0;
        end
        ST_DONE: begin
          oBusy <= 1'b0;
          oDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed cases plus randomized
// rectangles checked against a behavioural raster model.
module tb_rect_fill_engine;

  logic       iClk;
  logic       iReset;
  logic       iStart;
  logic [7:0] iX0, iX1;
  logic [6:0] iY0, iY1;
  logic [2:0] iColour;
  logic       iBank;
  logic       iOutline;
  logic       oBusy, oDone, oWren, oChipSelect;
  logic [14:0] oAddress;
  logic [2:0]  oData;

  int n_tests = 0;
  int n_fail  = 0;

  rect_fill_engine dut (
    .iClk        (iClk),
    .iReset      (iReset),
    .iStart      (iStart),
    .iX0         (iX0),
    .iY0         (iY0),
    .iX1         (iX1),
    .iY1         (iY1),
    .iColour     (iColour),
    .iBank       (iBank),
`ifdef RECT_OUTLINE_EN
    .iOutline    (iOutline),
`endif
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oAddress    (oAddress),
    .oData       (oData),
    .oWren       (oWren),
    .oChipSelect (oChipSelect)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: list of written addresses and number of walk cycles
  task automatic model(input int x0, input int y0, input int x1, input int y1,
                       input int outl, output int exp_q[$], output int walk);
    int xa, xb, ya, yb;
    exp_q = {};
    xa = (x0 < x1) ? x0 : x1;  xb = (x0 < x1) ? x1 : x0;
    ya = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
    if (xb > 159) xb = 159;
    if (yb > 119) yb = 119;
    if (xa > 159 || ya > 119) begin
      walk = 0;
    end else begin
      walk = (xb - xa + 1) * (yb - ya + 1);
      for (int y = ya; y <= yb; y++)
        for (int x = xa; x <= xb; x++)
          if (outl == 0 || x == xa || x == xb || y == ya || y == yb)
            exp_q.push_back(y * 160 + x);
    end
  endtask

  task automatic run_cmd(input string tag, input int x0, input int y0,
                         input int x1, input int y1, input int col,
                         input int bank, input int outl,
                         output int nwr, output int first_a, output int last_a);
    int exp_q[$];
    int walk, k, done_k, first_k, bad, limit, busy0, wr_at_done, busy_at_done;
    bit done;
`ifndef RECT_OUTLINE_EN
    outl = 0;
`endif
    model(x0, y0, x1, y1, outl, exp_q, walk);
    @(negedge iClk);
    iX0 = 8'(x0); iY0 = 7'(y0); iX1 = 8'(x1); iY1 = 7'(y1);
    iColour = 3'(col); iBank = 1'(bank); iOutline = 1'(outl);
    iStart = 1'b1;
    @(posedge iClk);
    k = 0; done = 0; done_k = -1; first_k = -1; bad = 0; nwr = 0;
    first_a = -1; last_a = -1; busy0 = 0; wr_at_done = 0; busy_at_done = 0;
    limit = walk + 20;
    while (!done && k < limit) begin
      @(negedge iClk);
      if (k == 0) busy0 = int'(oBusy);
      if (oWren) begin
        if (first_k < 0) begin first_k = k; first_a = int'(oAddress); end
        last_a = int'(oAddress);
        if (nwr >= exp_q.size() || int'(oAddress) != exp_q[nwr]) bad++;
        if (int'(oData) != col || int'(oChipSelect) != bank) bad++;
        nwr++;
      end
      if (oDone) begin
        done = 1; done_k = k;
        wr_at_done = int'(oWren); busy_at_done = int'(oBusy);
      end
      // Scramble inputs and poke iStart while busy: both must be ignored
      iX0 = 8'($urandom_range(0, 255)); iY0 = 7'($urandom_range(0, 127));
      iX1 = 8'($urandom_range(0, 255)); iY1 = 7'($urandom_range(0, 127));
      iColour = 3'($urandom_range(0, 7)); iBank = 1'($urandom_range(0, 1));
      iOutline = 1'($urandom_range(0, 1));
      iStart = oBusy ? 1'($urandom_range(0, 1)) : 1'b0;
      k++;
    end
    iStart = 1'b0;
    check({tag, " done_seen"}, int'(done), 1);
    check({tag, " busy_after_accept"}, busy0, 1);
    check({tag, " write_count"}, nwr, exp_q.size());
    check({tag, " bad_writes"}, bad, 0);
    check({tag, " done_cycle"}, done_k, 2 + walk);
    check({tag, " done_idle_outputs"}, wr_at_done + busy_at_done, 0);
    if (exp_q.size() > 0) check({tag, " first_write_cycle"}, first_k, 2);
  endtask

  initial begin
    int nwr, fa, la, cnt;
    iReset = 1'b1; iStart = 1'b0;
    iX0 = '0; iY0 = '0; iX1 = '0; iY1 = '0;
    iColour = '0; iBank = 1'b0; iOutline = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iReset = 1'b0;
    @(negedge iClk);
    check("rst oBusy", int'(oBusy), 0);
    check("rst oDone", int'(oDone), 0);
    check("rst oWren", int'(oWren), 0);
    check("rst oAddress", int'(oAddress), 0);
    check("rst oData", int'(oData), 0);
    check("rst oChipSelect", int'(oChipSelect), 0);

    run_cmd("small", 2, 3, 4, 4, 5, 1, 0, nwr, fa, la);
    check("small count", nwr, 6);
    check("small first", fa, 482);
    check("small last", la, 644);

    run_cmd("swapped", 10, 20, 3, 5, 2, 0, 0, nwr, fa, la);
    check("swapped count", nwr, 128);
    check("swapped first", fa, 803);
    check("swapped last", la, 3210);

    run_cmd("clipped", 150, 110, 255, 127, 7, 1, 0, nwr, fa, la);
    check("clipped count", nwr, 100);
    check("clipped last", la, 19199);

    run_cmd("offscreen", 200, 0, 255, 5, 3, 0, 0, nwr, fa, la);
    check("offscreen count", nwr, 0);

    run_cmd("single", 159, 119, 159, 119, 6, 1, 0, nwr, fa, la);
    check("single count", nwr, 1);
    check("single addr", fa, 19199);

    // Reset while the third of six pixels is on the bus
    @(negedge iClk);
    iX0 = 8'd2; iY0 = 7'd3; iX1 = 8'd4; iY1 = 7'd4;
    iColour = 3'd5; iBank = 1'b1; iOutline = 1'b0; iStart = 1'b1;
    @(posedge iClk);
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      @(negedge iClk);
      iStart = 1'b0;
      if (oWren) cnt++;
    end
    check("midreset reached_write3", cnt, 3);
    iReset = 1'b1;
    @(negedge iClk);
    check("midreset oWren", int'(oWren), 0);
    check("midreset oBusy", int'(oBusy), 0);
    check("midreset oDone", int'(oDone), 0);
    iReset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge iClk);
      cnt += int'(oDone) + int'(oWren);
    end
    check("midreset no_activity", cnt, 0);
    run_cmd("after_reset", 0, 0, 1, 1, 4, 0, 0, nwr, fa, la);
    check("after_reset count", nwr, 4);

`ifdef RECT_OUTLINE_EN
    run_cmd("outline", 0, 0, 3, 3, 1, 1, 1, nwr, fa, la);
    check("outline count", nwr, 12);
`endif

    for (int i = 0; i < 25; i++) begin
      int x0, y0, x1, y1, t;
      x0 = $urandom_range(0, 175);
      x1 = x0 + $urandom_range(0, 20);
      if (x1 > 255) x1 = 255;
      y0 = $urandom_range(0, 125);
      y1 = y0 + $urandom_range(0, 12);
      if (y1 > 127) y1 = 127;
      if ($urandom_range(0, 1) == 1) begin t = x0; x0 = x1; x1 = t; end
      if ($urandom_range(0, 1) == 1) begin t = y0; y0 = y1; y1 = t; end
      run_cmd($sformatf("rand%0d", i), x0, y0, x1, y1,
              $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 1), nwr, fa, la);
    end

    run_cmd("fullscreen", 0, 0, 159, 119, 3, 0, 0, nwr, fa, la);
    check("fullscreen count", nwr, 19200);
    check("fullscreen first", fa, 0);
    check("fullscreen last", la, 19199);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
